// File: rtl/dds_pkg.sv
// Shared constants for the multi-channel DDS engine.
// Mode and register encodings plus parameter-derived helpers.
package dds_pkg;

  localparam logic [1:0] MODE_RAMP = 2'd0;
  localparam logic [1:0] MODE_TRI  = 2'd1;
  localparam logic [1:0] MODE_SQR  = 2'd2;
  localparam logic [1:0] MODE_DC   = 2'd3;

  localparam logic [2:0] REG_FREQ  = 3'd0;
  localparam logic [2:0] REG_PHASE = 3'd1;
  localparam logic [2:0] REG_MODE  = 3'd2;
  localparam logic [2:0] REG_LEVEL = 3'd3;
  localparam logic [2:0] REG_AMP   = 3'd4;

  function automatic int unsigned midscale(input int unsigned dac_w);
    return 32'd1 << (dac_w - 1);
  endfunction

  function automatic int unsigned unity_amp(input int unsigned amp_w);
    return 32'd1 << amp_w;
  endfunction

endpackage

// File: rtl/dds_channel.sv
// One DDS channel: shadow/active banks, phase accumulator and
// a 3-stage phase -> waveform -> gain pipeline.
module dds_channel
  import dds_pkg::*;
#(
  parameter int FW_W  = 32,
  parameter int DAC_W = 14,
  parameter int AMP_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_reg,
  input  logic [31:0]      wr_data,
  input  logic             commit,
  input  logic             phase_sync,
  output logic [DAC_W-1:0] dout
);

  localparam logic [DAC_W-1:0] MID   = DAC_W'(midscale(DAC_W));
  localparam logic [DAC_W-1:0] MAXV  = {DAC_W{1'b1}};
  localparam logic [AMP_W:0]   UNITY = (AMP_W+1)'(unity_amp(AMP_W));
  localparam logic [FW_W-1:0]  LVL0  = {1'b1, {(FW_W-1){1'b0}}};
  localparam int PW = DAC_W + AMP_W + 2;

  logic [FW_W-1:0] sh_freq, sh_poff, sh_level;
  logic [1:0]      sh_mode;
  logic [AMP_W:0]  sh_amp;
  logic [FW_W-1:0] ac_freq, ac_poff, ac_level;
  logic [1:0]      ac_mode;
  logic [AMP_W:0]  ac_amp;

  logic [FW_W-1:0] nx_freq, nx_poff, nx_level;
  logic [1:0]      nx_mode;
  logic [AMP_W:0]  nx_amp, amp_in;

  logic [FW_W-1:0] acc, p;
  logic [1:0]      mode1;
  logic [FW_W-1:0] lvl1;
  logic [AMP_W:0]  amp1, amp2;
  logic [DAC_W-1:0] raw, raw_c, tri_t;

  logic signed [DAC_W:0]   s;
  logic signed [PW-1:0]    prod, sh;
  logic signed [DAC_W+1:0] y, o;
  logic [DAC_W-1:0]        out_c;

  // Shadow bank as it will look after this cycle's write
  always_comb begin
    nx_freq  = sh_freq;
    nx_poff  = sh_poff;
    nx_mode  = sh_mode;
    nx_level = sh_level;
    nx_amp   = sh_amp;
    amp_in   = wr_data[AMP_W:0];
    if (wr_en) begin
      unique case (1'b1)
        (wr_reg == REG_FREQ):  nx_freq  = wr_data[FW_W-1:0];
        (wr_reg == REG_PHASE): nx_poff  = wr_data[FW_W-1:0];
        (wr_reg == REG_MODE):  nx_mode  = wr_data[1:0];
        (wr_reg == REG_LEVEL): nx_level = wr_data[FW_W-1:0];
        (wr_reg == REG_AMP):
          nx_amp = (amp_in > UNITY) ? UNITY : amp_in;
        default: ;
      endcase
    end
  end

  // Shadow captures writes; active takes the post-write shadow on commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_freq  <= '0;
      sh_poff  <= '0;
      sh_mode  <= MODE_RAMP;
      sh_level <= LVL0;
      sh_amp   <= UNITY;
      ac_freq  <= '0;
      ac_poff  <= '0;
      ac_mode  <= MODE_RAMP;
      ac_level <= LVL0;
      ac_amp   <= UNITY;
    end else begin
      sh_freq  <= nx_freq;
      sh_poff  <= nx_poff;
      sh_mode  <= nx_mode;
      sh_level <= nx_level;
      sh_amp   <= nx_amp;
      if (commit) begin
        ac_freq  <= nx_freq;
        ac_poff  <= nx_poff;
        ac_mode  <= nx_mode;
        ac_level <= nx_level;
        ac_amp   <= nx_amp;
      end
    end
  end

  // Phase accumulator, cleared by phase_sync
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else if (phase_sync) acc <= '0;
    else acc <= acc + ac_freq;
  end

  // S1: offset phase; shape controls travel with the sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p     <= '0;
      mode1 <= MODE_RAMP;
      lvl1  <= LVL0;
      amp1  <= UNITY;
    end else begin
      p     <= acc + ac_poff;
      mode1 <= ac_mode;
      lvl1  <= ac_level;
      amp1  <= ac_amp;
    end
  end

  // Waveform shaping from the offset phase
  always_comb begin
    tri_t = p[FW_W-2 -: DAC_W];
    raw_c = MID;
    unique case (mode1)
      MODE_RAMP: raw_c = p[FW_W-1 -: DAC_W];
      MODE_TRI:  raw_c = p[FW_W-1] ? ~tri_t : tri_t;
      MODE_SQR:  raw_c = (p < lvl1) ? MAXV : '0;
      MODE_DC:   raw_c = lvl1[FW_W-1 -: DAC_W];
    endcase
  end

  // S2: raw waveform register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw  <= MID;
      amp2 <= UNITY;
    end else begin
      raw  <= raw_c;
      amp2 <= amp1;
    end
  end

  // Gain about midscale, back to offset-binary with saturation
  always_comb begin
    s    = $signed({1'b0, raw}) - $signed({1'b0, MID});
    prod = PW'(s) * PW'($signed({1'b0, amp2}));
    sh   = prod >>> AMP_W;
    y    = sh[DAC_W+1:0];
    o    = y + $signed({2'b00, MID});
    if (o < 0) out_c = '0;
    else if (o > $signed({2'b00, MAXV})) out_c = MAXV;
    else out_c = o[DAC_W-1:0];
  end

  // S3: output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout <= MID;
    else dout <= out_c;
  end

endmodule

// File: rtl/dds_multi_ch.sv
// Multi-channel DDS top: write decode, commit/sync fan-out
// and pipeline-fill indicator.
module dds_multi_ch
  import dds_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int FW_W   = 32,
  parameter int DAC_W  = 14,
  parameter int AMP_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [2:0]              wr_ch,
  input  logic [2:0]              wr_reg,
  input  logic [31:0]             wr_data,
  input  logic                    commit,
  input  logic                    phase_sync,
  output logic [NUM_CH*DAC_W-1:0] dout,
  output logic                    dout_valid
);

  logic [NUM_CH-1:0] ch_we;
  logic [2:0]        vld_sr;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_we[k] = wr_en && (wr_ch == 3'(k));
    dds_channel #(
      .FW_W  (FW_W),
      .DAC_W (DAC_W),
      .AMP_W (AMP_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (ch_we[k]),
      .wr_reg     (wr_reg),
      .wr_data    (wr_data),
      .commit     (commit),
      .phase_sync (phase_sync),
      .dout       (dout[k*DAC_W +: DAC_W])
    );
  end

  // Valid after the three pipeline stages have filled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_sr <= '0;
    else vld_sr <= {vld_sr[1:0], 1'b1};
  end

  assign dout_valid = vld_sr[2];

endmodule

// File: tb/tb_dds_multi_ch.sv
// Bench for dds_multi_ch: directed and random register traffic
// against a sample-level reference model.
module tb_dds_multi_ch;

  localparam int NUM_CH = 2;
  localparam int FW_W   = 32;
  localparam int DAC_W  = 14;
  localparam int AMP_W  = 12;
  localparam int MID    = 8192;
  localparam int MAXV   = 16383;
  localparam int UNITY  = 4096;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    wr_en = 1'b0;
  logic [2:0]              wr_ch = '0;
  logic [2:0]              wr_reg = '0;
  logic [31:0]             wr_data = '0;
  logic                    commit = 1'b0;
  logic                    phase_sync = 1'b0;
  logic [NUM_CH*DAC_W-1:0] dout;
  logic                    dout_valid;

  int total = 0;
  int bad = 0;

  logic [31:0] m_sfreq[NUM_CH], m_spoff[NUM_CH], m_slvl[NUM_CH];
  logic [31:0] m_afreq[NUM_CH], m_apoff[NUM_CH], m_alvl[NUM_CH];
  int          m_smode[NUM_CH], m_samp[NUM_CH];
  int          m_amode[NUM_CH], m_aamp[NUM_CH];
  logic [31:0] m_acc[NUM_CH];
  int          m_pipe[NUM_CH][3];
  int          m_vc;

  dds_multi_ch #(
    .NUM_CH (NUM_CH),
    .FW_W   (FW_W),
    .DAC_W  (DAC_W),
    .AMP_W  (AMP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_reg     (wr_reg),
    .wr_data    (wr_data),
    .commit     (commit),
    .phase_sync (phase_sync),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  function automatic int sample(input logic [31:0] a, input logic [31:0] po,
                                input logic [31:0] lv, input int md,
                                input int amp);
    logic [31:0] ph;
    int raw, t, s, y, o;
    longint prod;
    ph = a + po;
    case (md)
      0: raw = int'(ph >> 18);
      1: begin
        t = int'((ph >> 17) % 32'd16384);
        raw = (ph >= 32'h8000_0000) ? MAXV - t : t;
      end
      2: raw = (ph < lv) ? MAXV : 0;
      default: raw = int'(lv >> 18);
    endcase
    s = raw - MID;
    prod = longint'(s) * longint'(amp);
    if (prod >= 0) y = int'(prod / 4096);
    else y = -int'((-prod + 4095) / 4096);
    o = y + MID;
    if (o < 0) o = 0;
    if (o > MAXV) o = MAXV;
    return o;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_sfreq[c] = 0; m_spoff[c] = 0; m_slvl[c] = 32'h8000_0000;
      m_smode[c] = 0; m_samp[c] = UNITY;
      m_afreq[c] = 0; m_apoff[c] = 0; m_alvl[c] = 32'h8000_0000;
      m_amode[c] = 0; m_aamp[c] = UNITY;
      m_acc[c] = 0;
      for (int j = 0; j < 3; j++) m_pipe[c][j] = MID;
    end
    m_vc = 0;
  endtask

  task automatic model_edge();
    int a;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      m_pipe[c][2] = m_pipe[c][1];
      m_pipe[c][1] = m_pipe[c][0];
      m_pipe[c][0] = sample(m_acc[c], m_apoff[c], m_alvl[c],
                            m_amode[c], m_aamp[c]);
    end
    if (wr_en && wr_ch < NUM_CH) begin
      case (wr_reg)
        3'd0: m_sfreq[wr_ch] = wr_data;
        3'd1: m_spoff[wr_ch] = wr_data;
        3'd2: m_smode[wr_ch] = int'(wr_data % 4);
        3'd3: m_slvl[wr_ch] = wr_data;
        3'd4: begin
          a = int'(wr_data % 8192);
          m_samp[wr_ch] = (a > UNITY) ? UNITY : a;
        end
        default: ;
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (phase_sync) m_acc[c] = 0;
      else m_acc[c] = m_acc[c] + m_afreq[c];
      if (commit) begin
        m_afreq[c] = m_sfreq[c]; m_apoff[c] = m_spoff[c];
        m_alvl[c] = m_slvl[c]; m_amode[c] = m_smode[c];
        m_aamp[c] = m_samp[c];
      end
    end
    if (m_vc < 3) m_vc++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs();
    chk("dout_valid", int'(dout_valid), (m_vc >= 3) ? 1 : 0);
    if (m_vc >= 3) begin
      for (int c = 0; c < NUM_CH; c++)
        chk($sformatf("dout%0d", c),
            int'(dout[c*DAC_W +: DAC_W]), m_pipe[c][2]);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_valid", int'(dout_valid), 0);
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("rst_dout%0d", c), int'(dout[c*DAC_W +: DAC_W]), MID);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    wr_en = 1'b0;
    commit = 1'b0;
    phase_sync = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int ch, input int rg, input logic [31:0] d,
                    input logic com);
    wr_en = 1'b1;
    wr_ch = 3'(ch);
    wr_reg = 3'(rg);
    wr_data = d;
    commit = com;
    tick();
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
  endtask

  task automatic do_sync();
    phase_sync = 1'b1;
    tick();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
    run(5);

    // ramp on ch0
    wr(0, 0, 32'h1000_0000, 1'b0);
    do_commit();
    run(36);

    // triangles, ch1 half a period ahead
    wr(0, 0, 32'h0800_0000, 1'b0);
    wr(1, 0, 32'h0800_0000, 1'b0);
    wr(1, 1, 32'h8000_0000, 1'b0);
    wr(0, 2, 32'd1, 1'b0);
    wr(1, 2, 32'd1, 1'b0);
    do_commit();
    do_sync();
    run(40);

    // 25% square at half gain
    wr(0, 2, 32'd2, 1'b0);
    wr(0, 3, 32'h4000_0000, 1'b0);
    wr(0, 4, 32'h0000_0800, 1'b0);
    do_commit();
    run(24);

    // shadow-only write, then write-through with commit
    wr(0, 0, 32'h0200_0000, 1'b0);
    run(20);
    wr(0, 0, 32'h0300_0000, 1'b1);
    run(12);

    // ignored writes and amp clamp
    wr(5, 0, 32'h1234_5678, 1'b0);
    wr(0, 6, 32'h1234_5678, 1'b0);
    do_commit();
    run(8);
    wr(1, 2, 32'd0, 1'b0);
    wr(1, 4, 32'h0000_1FFF, 1'b1);
    run(12);

    // DC mode and sync combined with commit
    wr(1, 2, 32'd3, 1'b0);
    wr(1, 3, 32'h2345_6789, 1'b0);
    phase_sync = 1'b1;
    do_commit();
    run(8);

    // random register traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        wr_en = 1'b1;
        wr_ch = 3'($urandom_range(0, 7));
        wr_reg = 3'($urandom_range(0, 7));
        wr_data = $urandom;
      end
      commit = ($urandom_range(0, 9) == 0);
      phase_sync = ($urandom_range(0, 29) == 0);
      tick();
    end

    // reset mid-operation drops pending shadow writes
    wr(0, 0, 32'h0F00_0000, 1'b0);
    wr(0, 2, 32'd1, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_state();
    tick();
    rst = 1'b0;
    run(4);
    do_commit();
    run(10);
    wr(0, 0, 32'h0400_0000, 1'b1);
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
